// File: rtl/dsa_pkg.sv
// Shared types for the DSA bilinear-interpolation controller.
package dsa_pkg;

    localparam int PIX_IDX_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } dsa_state_t;

endpackage

// File: rtl/dsa_ctrl_fsm.sv
// Frame sequencer: start -> next_pixel one cycle later; one pixel per REQ/WAIT pair.
// Stalls in WAIT until done_pixel; start is only accepted while idle.
module dsa_ctrl_fsm
    import dsa_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 done_pixel,
    input  logic [PIX_IDX_W-1:0] total_pixels,
    output logic                 busy,
    output logic                 ready,
    output logic                 next_pixel,
    output logic [PIX_IDX_W-1:0] pixel_index
);

    localparam int                 FALLBACK_INT = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [PIX_IDX_W-1:0] FALLBACK_CNT = PIX_IDX_W'(FALLBACK_INT);

    dsa_state_t           state;
    dsa_state_t           state_nxt;
    logic [PIX_IDX_W-1:0] count;
    logic                 last_pixel;

    assign last_pixel = (pixel_index == (count - PIX_IDX_W'(1)));

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        ready      = 1'b0;
        next_pixel = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_REQ;
            end
            S_REQ: begin
                busy       = 1'b1;
                next_pixel = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (done_pixel) state_nxt = last_pixel ? S_DONE : S_REQ;
            end
            S_DONE: begin
                ready     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pixel_index <= '0;
            count       <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                // A zero request means "whole image".
                count       <= (total_pixels == '0) ? FALLBACK_CNT : total_pixels;
                pixel_index <= '0;
            end else if (state == S_WAIT && done_pixel && !last_pixel) begin
                pixel_index <= pixel_index + PIX_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsa_ctrl_fsm.sv
// Directed bench for dsa_ctrl_fsm; inputs change and outputs are sampled 1ns after each rising edge.
module tb_dsa_ctrl_fsm;
    import dsa_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done_pixel = 1'b0;
    logic [15:0] total_pixels = 16'd0;
    logic        busy, ready, next_pixel;
    logic [15:0] pixel_index;

    int total = 0;
    int bad = 0;

    dsa_ctrl_fsm #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .done_pixel   (done_pixel),
        .total_pixels (total_pixels),
        .busy         (busy),
        .ready        (ready),
        .next_pixel   (next_pixel),
        .pixel_index  (pixel_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, ready, next_pixel} !== 3'b010 || pixel_index !== 16'd0 || dut.state !== S_IDLE) begin
            bad++;
            $display("FAIL reset_hold: busy/ready/next=%b idx=%0d state=%0d, want 010 idx=0 state=0",
                     {busy, ready, next_pixel}, pixel_index, dut.state);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({busy, ready, next_pixel} !== 3'b010 || dut.state !== S_IDLE) begin
            bad++;
            $display("FAIL reset_release: busy/ready/next=%b state=%0d, want 010 state=0",
                     {busy, ready, next_pixel}, dut.state);
        end
    endtask

    // Runs one frame with done_pixel one cycle after each next_pixel; stray_at>=0 injects a start in WAIT.
    task automatic run_frame(input logic [15:0] tp, input int exp_n, input int stray_at, input string name);
        int good;
        good = 0;
        start        = 1'b1;
        total_pixels = tp;
        tick();
        start        = 1'b0;
        total_pixels = 16'd3;
        for (int i = 0; i < exp_n; i++) begin
            if (next_pixel === 1'b1 && pixel_index === 16'(i) && busy === 1'b1 && ready === 1'b0) good++;
            tick();
            if (next_pixel === 1'b0 && busy === 1'b1 && dut.state === S_WAIT) good++;
            if (i == stray_at) begin
                start        = 1'b1;
                total_pixels = 16'd2;
                tick();
                start        = 1'b0;
                total++;
                if (dut.state !== S_WAIT || pixel_index !== 16'(i) || next_pixel !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_stray_start: state=%0d idx=%0d next=%b, want state=2 idx=%0d next=0",
                             name, dut.state, pixel_index, next_pixel, i);
                end
            end
            done_pixel = 1'b1;
            tick();
            done_pixel = 1'b0;
        end
        total++;
        if (good !== 2 * exp_n) begin
            bad++;
            $display("FAIL %s_pulses: good_cycles=%0d, want %0d", name, good, 2 * exp_n);
        end
        total++;
        if (dut.state !== S_DONE || ready !== 1'b1 || busy !== 1'b0 || next_pixel !== 1'b0
            || pixel_index !== 16'(exp_n - 1)) begin
            bad++;
            $display("FAIL %s_done: state=%0d ready=%b busy=%b next=%b idx=%0d, want state=3 ready=1 busy=0 next=0 idx=%0d",
                     name, dut.state, ready, busy, next_pixel, pixel_index, exp_n - 1);
        end
        tick();
        total++;
        if (dut.state !== S_IDLE || ready !== 1'b1 || busy !== 1'b0 || pixel_index !== 16'(exp_n - 1)) begin
            bad++;
            $display("FAIL %s_idle: state=%0d ready=%b busy=%b idx=%0d, want state=0 ready=1 busy=0 idx=%0d",
                     name, dut.state, ready, busy, pixel_index, exp_n - 1);
        end
    endtask

    task automatic test_full_frame();
        run_frame(16'd64, 64, -1, "frame64");
    endtask

    task automatic test_back_to_back();
        tick();
        tick();
        total++;
        if (next_pixel !== 1'b0 || dut.state !== S_IDLE || pixel_index !== 16'd63) begin
            bad++;
            $display("FAIL b2b_gap: next=%b state=%0d idx=%0d, want next=0 state=0 idx=63",
                     next_pixel, dut.state, pixel_index);
        end
        run_frame(16'd64, 64, -1, "b2b");
    endtask

    task automatic test_fallback();
        run_frame(16'd0, 64, -1, "fallback");
    endtask

    task automatic test_single_pixel();
        run_frame(16'd1, 1, -1, "single");
    endtask

    task automatic test_stray_start();
        run_frame(16'd8, 8, 5, "stray");
    endtask

    task automatic test_done_held();
        int good;
        good = 0;
        done_pixel   = 1'b1;
        start        = 1'b1;
        total_pixels = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (next_pixel === 1'b1 && pixel_index === 16'(i)) good++;
            tick();
            if (next_pixel === 1'b0 && dut.state === S_WAIT && pixel_index === 16'(i)) good++;
            tick();
        end
        total++;
        if (good !== 8) begin
            bad++;
            $display("FAIL held_done_cadence: good_cycles=%0d, want 8", good);
        end
        total++;
        if (dut.state !== S_DONE || pixel_index !== 16'd3) begin
            bad++;
            $display("FAIL held_done_end: state=%0d idx=%0d, want state=3 idx=3", dut.state, pixel_index);
        end
        done_pixel = 1'b0;
        tick();
        total++;
        if (dut.state !== S_IDLE || ready !== 1'b1) begin
            bad++;
            $display("FAIL held_done_idle: state=%0d ready=%b, want state=0 ready=1", dut.state, ready);
        end
    endtask

    task automatic test_mid_reset();
        start        = 1'b1;
        total_pixels = 16'd64;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            done_pixel = 1'b1;
            tick();
            done_pixel = 1'b0;
        end
        tick();
        total++;
        if (dut.state !== S_WAIT || pixel_index !== 16'd10) begin
            bad++;
            $display("FAIL midrst_pre: state=%0d idx=%0d, want state=2 idx=10", dut.state, pixel_index);
        end
        rst = 1'b1;
        #1;
        total++;
        if (dut.state !== S_IDLE || pixel_index !== 16'd0 || busy !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_async: state=%0d idx=%0d busy=%b ready=%b, want state=0 idx=0 busy=0 ready=1",
                     dut.state, pixel_index, busy, ready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (dut.state !== S_IDLE || next_pixel !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after: state=%0d next=%b, want state=0 next=0", dut.state, next_pixel);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_fallback();
        test_single_pixel();
        test_stray_start();
        test_done_held();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
